dma_ch_arbiter: RTL and testbench

Four-channel round-robin request arbiter for the DMA controller. It sits directly upstream of the 2-to-4 channel-select decoder, and its `gnt_en_o`/`gnt_idx_o` outputs drive the decoder's enable and 2-bit select inputs. It holds each grant for a whole transfer, or for a bounded burst when the burst limit is compiled in. Between any two grants it forces a one-cycle gap, so the decoder's one-hot output never switches directly from one channel to another.

---
 rtl/dma_ch_arbiter_if.sv | 31 +++
 rtl/dma_ch_arbiter.sv | 104 ++++++++++
 tb/tb_dma_ch_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_ch_arbiter_if.sv
// Handshake bundle between the DMA channels and the round-robin channel arbiter.
// The arbiter uses the slave modport; the channel side uses the master modport.
interface dma_ch_arbiter_if;
    logic [3:0] req_i;
    logic       beat_i;
    logic       last_i;
    logic       gnt_en_o;
    logic [1:0] gnt_idx_o;
    logic       busy_o;
    logic       done_o;

    modport slave (
        input  req_i,
        input  beat_i,
        input  last_i,
        output gnt_en_o,
        output gnt_idx_o,
        output busy_o,
        output done_o
    );

    modport master (
        output req_i,
        output beat_i,
        output last_i,
        input  gnt_en_o,
        input  gnt_idx_o,
        input  busy_o,
        input  done_o
    );
endinterface

// File: rtl/dma_ch_arbiter.sv
// Four-channel round-robin DMA arbiter with a forced one-cycle gap between grants.
// Define DMA_ARB_BURST_LIMIT_EN to release a grant after BURST_MAX accepted beats.
module dma_ch_arbiter #(
    parameter int BURST_MAX = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    dma_ch_arbiter_if.slave  bus
);

    localparam int CNT_W = (BURST_MAX > 2) ? $clog2(BURST_MAX) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic [1:0]         winner;
    logic [1:0]         cand;
    logic               at_limit;
    logic               release_now;

    assign at_limit = (cnt_q == CNT_W'(BURST_MAX - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        winner      = ptr_q;
        cand        = 2'd0;
        release_now = 1'b0;

        // Scan from the farthest offset back to ptr so the nearest requester wins.
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (bus.req_i[cand]) begin
                winner = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.req_i != 4'd0) begin
                    state_d = BUSY;
                    idx_d   = winner;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (!bus.req_i[idx_q]) begin
                    release_now = 1'b1;
                end else if (bus.beat_i && bus.last_i) begin
                    release_now = 1'b1;
`ifdef DMA_ARB_BURST_LIMIT_EN
                end else if (bus.beat_i && at_limit) begin
                    release_now = 1'b1;
`endif
                end

                if (release_now) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + 2'd1;
                    done_d  = 1'b1;
                end else if (bus.beat_i && !at_limit) begin
                    // Saturating, so long unlimited transfers never wrap the count.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.gnt_en_o  = (state_q == BUSY);
    assign bus.busy_o    = (state_q == BUSY);
    assign bus.gnt_idx_o = idx_q;
    assign bus.done_o    = done_q;

endmodule

// File: tb/tb_dma_ch_arbiter.sv
// Directed testbench for dma_ch_arbiter: reset, single transfer, fairness, abort,
// burst limit and asynchronous reset while a grant is active.
module tb_dma_ch_arbiter;

    localparam int BURST_MAX = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    dma_ch_arbiter_if bus();

    dma_ch_arbiter #(.BURST_MAX(BURST_MAX)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_ni      = 1'b0;
        bus.req_i   = 4'hF;
        bus.beat_i  = 1'b0;
        bus.last_i  = 1'b0;
        tick();
        tick();
        tests_run++;
        if (bus.gnt_en_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_gnt_en: got %b expected 0", bus.gnt_en_o);
        end
        tests_run++;
        if (bus.gnt_idx_o !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_gnt_idx: got %0d expected 0", bus.gnt_idx_o);
        end
        tests_run++;
        if (bus.busy_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy_o);
        end
        tests_run++;
        if (bus.done_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_done: got %b expected 0", bus.done_o);
        end
        rst_ni = 1'b1;
        tick();
        tests_run++;
        if (bus.gnt_en_o !== 1'b1 || bus.gnt_idx_o !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_first_grant: got en=%b idx=%0d expected en=1 idx=0",
                     bus.gnt_en_o, bus.gnt_idx_o);
        end
        bus.req_i  = 4'h0;
        tick();
        tests_run++;
        if (bus.gnt_en_o !== 1'b0 || bus.done_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_abort_release: got en=%b done=%b expected en=0 done=1",
                     bus.gnt_en_o, bus.done_o);
        end
        tick();
    endtask

    // Pointer is 1 on entry; req 0100 wins channel 2 and the release moves ptr to 3.
    task automatic test_single_transfer;
        int high_cycles;
        bus.req_i = 4'b0100;
        tick();
        high_cycles = (bus.gnt_en_o === 1'b1) ? 1 : 0;
        tests_run++;
        if (bus.gnt_idx_o !== 2'd2 || bus.gnt_en_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_grant: got en=%b idx=%0d expected en=1 idx=2",
                     bus.gnt_en_o, bus.gnt_idx_o);
        end
        for (int k = 0; k < 3; k++) begin
            bus.beat_i = 1'b1;
            bus.last_i = (k == 2);
            tick();
            if (bus.gnt_en_o === 1'b1) high_cycles++;
        end
        tests_run++;
        if (high_cycles != 3) begin
            tests_failed++;
            $display("[TB] FAIL single_high_cycles: got %0d expected 3", high_cycles);
        end
        tests_run++;
        if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_done: got done=%b busy=%b expected done=1 busy=0",
                     bus.done_o, bus.busy_o);
        end
        bus.beat_i = 1'b0;
        bus.last_i = 1'b0;
        bus.req_i  = 4'h0;
        tick();
        tests_run++;
        if (bus.done_o !== 1'b0 || bus.gnt_idx_o !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL single_done_pulse: got done=%b idx=%0d expected done=0 idx=2",
                     bus.done_o, bus.gnt_idx_o);
        end
        bus.req_i = 4'b1100;
        tick();
        tests_run++;
        if (bus.gnt_idx_o !== 2'd3) begin
            tests_failed++;
            $display("[TB] FAIL single_next_ptr: got idx=%0d expected 3", bus.gnt_idx_o);
        end
        bus.beat_i = 1'b1;
        bus.last_i = 1'b1;
        bus.req_i  = 4'h0;
        tick();
        bus.beat_i = 1'b0;
        bus.last_i = 1'b0;
        tick();
    endtask

    task automatic test_fairness;
        logic [1:0] exp_idx;
        bus.req_i = 4'hF;
        for (int g = 0; g < 5; g++) begin
            exp_idx = 2'(g % 4);
            tick();
            tests_run++;
            if (bus.gnt_en_o !== 1'b1 || bus.gnt_idx_o !== exp_idx) begin
                tests_failed++;
                $display("[TB] FAIL fair_grant_%0d: got en=%b idx=%0d expected en=1 idx=%0d",
                         g, bus.gnt_en_o, bus.gnt_idx_o, exp_idx);
            end
            bus.beat_i = 1'b1;
            bus.last_i = 1'b1;
            tick();
            tests_run++;
            if (bus.gnt_en_o !== 1'b0 || bus.done_o !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL fair_gap_%0d: got en=%b done=%b expected en=0 done=1",
                         g, bus.gnt_en_o, bus.done_o);
            end
            bus.beat_i = 1'b0;
            bus.last_i = 1'b0;
        end
        bus.req_i = 4'h0;
        tick();
    endtask

    // Pointer is 1 on entry after the fairness rotation ended on channel 0.
    task automatic test_abort;
        bus.req_i = 4'b0110;
        tick();
        tests_run++;
        if (bus.gnt_idx_o !== 2'd1 || bus.gnt_en_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_grant: got en=%b idx=%0d expected en=1 idx=1",
                     bus.gnt_en_o, bus.gnt_idx_o);
        end
        bus.beat_i = 1'b1;
        tick();
        bus.req_i = 4'b0100;
        tick();
        tests_run++;
        if (bus.gnt_en_o !== 1'b0 || bus.done_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_release: got en=%b done=%b expected en=0 done=1",
                     bus.gnt_en_o, bus.done_o);
        end
        bus.beat_i = 1'b0;
        tick();
        tests_run++;
        if (bus.gnt_en_o !== 1'b1 || bus.gnt_idx_o !== 2'd2 || bus.done_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_next: got en=%b idx=%0d done=%b expected en=1 idx=2 done=0",
                     bus.gnt_en_o, bus.gnt_idx_o, bus.done_o);
        end
        bus.beat_i = 1'b1;
        bus.last_i = 1'b1;
        bus.req_i  = 4'h0;
        tick();
        bus.beat_i = 1'b0;
        bus.last_i = 1'b0;
        tick();
    endtask

    // Pointer is 3 on entry, so req 0011 grants channel 0 first.
    task automatic test_burst_limit;
        int held;
        bus.req_i = 4'b0011;
        tick();
        tests_run++;
        if (bus.gnt_idx_o !== 2'd0 || bus.gnt_en_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL burst_grant: got en=%b idx=%0d expected en=1 idx=0",
                     bus.gnt_en_o, bus.gnt_idx_o);
        end
        held = 0;
        bus.beat_i = 1'b1;
`ifdef DMA_ARB_BURST_LIMIT_EN
        for (int k = 0; k < BURST_MAX; k++) begin
            tick();
            if (bus.gnt_en_o === 1'b1) held++;
        end
        tests_run++;
        if (held != BURST_MAX - 1 || bus.done_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL burst_limit_release: got held=%0d done=%b expected held=%0d done=1",
                     held, bus.done_o, BURST_MAX - 1);
        end
        tick();
        tests_run++;
        if (bus.gnt_en_o !== 1'b1 || bus.gnt_idx_o !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL burst_next_grant: got en=%b idx=%0d expected en=1 idx=1",
                     bus.gnt_en_o, bus.gnt_idx_o);
        end
`else
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.gnt_en_o === 1'b1 && bus.gnt_idx_o === 2'd0) held++;
        end
        tests_run++;
        if (held != 10) begin
            tests_failed++;
            $display("[TB] FAIL burst_unlimited_hold: got %0d held cycles expected 10", held);
        end
`endif
        bus.last_i = 1'b1;
        bus.req_i  = 4'h0;
        tick();
        bus.beat_i = 1'b0;
        bus.last_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy;
        bus.req_i = 4'b1000;
        tick();
        tests_run++;
        if (bus.gnt_idx_o !== 2'd3 || bus.gnt_en_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_grant: got en=%b idx=%0d expected en=1 idx=3",
                     bus.gnt_en_o, bus.gnt_idx_o);
        end
        #3;
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if (bus.gnt_en_o !== 1'b0 || bus.gnt_idx_o !== 2'd0 || bus.busy_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_async: got en=%b idx=%0d busy=%b expected en=0 idx=0 busy=0",
                     bus.gnt_en_o, bus.gnt_idx_o, bus.busy_o);
        end
        tick();
        tests_run++;
        if (bus.done_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_no_done: got %b expected 0", bus.done_o);
        end
        @(negedge clk_i);
        rst_ni    = 1'b1;
        bus.req_i = 4'b1001;
        tick();
        tests_run++;
        if (bus.gnt_en_o !== 1'b1 || bus.gnt_idx_o !== 2'd0 || bus.done_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_regrant: got en=%b idx=%0d done=%b expected en=1 idx=0 done=0",
                     bus.gnt_en_o, bus.gnt_idx_o, bus.done_o);
        end
    endtask

    initial begin
        bus.req_i  = 4'h0;
        bus.beat_i = 1'b0;
        bus.last_i = 1'b0;
        test_reset();
        test_single_transfer();
        test_fairness();
        test_abort();
        test_burst_limit();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
